// File: rtl/div_rect_seq_if.sv
`default_nettype none
// =====================================================================
// div_rect_seq_if : frame-controller / map-RAM / extractor signal bundle
//                   for div_rect_seq (o_timeout with DIV_RECT_SEQ_TIMEOUT_EN)
// Rev 1.0
// =====================================================================
interface div_rect_seq_if #(
   parameter int AW = 10
);
   logic          i_start;
   logic [7:0]    i_smax;
   logic          o_busy;
   logic          o_done;
   logic          o_rd_en;
   logic [AW-1:0] o_rd_addr;
   logic          i_rd_data;
   logic          o_valid;
   logic          o_wb;
   logic [7:0]    o_smax;
   logic          o_item_rst_n;
   logic          i_finish;
`ifdef DIV_RECT_SEQ_TIMEOUT_EN
   logic          o_timeout;

   modport slave (
      input  i_start, i_smax, i_rd_data, i_finish,
      output o_busy, o_done, o_rd_en, o_rd_addr, o_valid, o_wb, o_smax,
             o_item_rst_n, o_timeout
   );
   modport master (
      output i_start, i_smax, i_rd_data, i_finish,
      input  o_busy, o_done, o_rd_en, o_rd_addr, o_valid, o_wb, o_smax,
             o_item_rst_n, o_timeout
   );
`else
   modport slave (
      input  i_start, i_smax, i_rd_data, i_finish,
      output o_busy, o_done, o_rd_en, o_rd_addr, o_valid, o_wb, o_smax,
             o_item_rst_n
   );
   modport master (
      output i_start, i_smax, i_rd_data, i_finish,
      input  o_busy, o_done, o_rd_en, o_rd_addr, o_valid, o_wb, o_smax,
             o_item_rst_n
   );
`endif
endinterface
`default_nettype wire

// File: rtl/div_rect_seq.sv
`default_nettype none
// =====================================================================
// div_rect_seq : streams the corrosion map into the rectangle extractor,
//                one pixel per SLOT cycles (timeout via DIV_RECT_SEQ_TIMEOUT_EN)
// Rev 1.0
// =====================================================================
module div_rect_seq #(
   parameter int DX      = 32,
   parameter int DY      = 24,
   parameter int AW      = 10,
   parameter int SLOT    = 8,
   parameter int CLR_LEN = 2
`ifdef DIV_RECT_SEQ_TIMEOUT_EN
   ,
   parameter int TO_CYC  = 1024
`endif
) (
   input  wire logic     sys_clk,
   input  wire logic     sys_rst_n,
   div_rect_seq_if.slave bus
);

   typedef enum logic [2:0] {
      IDLE     = 3'd0,
      CLR      = 3'd1,
      FETCH    = 3'd2,
      ISSUE    = 3'd3,
      GAP      = 3'd4,
      WAIT_FIN = 3'd5,
      DONE     = 3'd6
   } state_t;

   localparam logic [AW-1:0] LAST_PIX = AW'(DX * DY - 1);
   localparam logic [3:0]    SLOT_END = 4'(SLOT - 1);
   localparam logic [2:0]    CLR_END  = 3'(CLR_LEN - 1);

   state_t        state;
   state_t        state_nx;
   logic [2:0]    clr_cnt;
   logic [3:0]    slot_cnt;
   logic [AW-1:0] pix_idx;
   logic          fin_d;
   logic [7:0]    smax;
   logic          fin_rise;
   logic          frame_end;

   assign fin_rise = bus.i_finish & ~fin_d;

`ifdef DIV_RECT_SEQ_TIMEOUT_EN
   localparam logic [15:0] TO_END = 16'(TO_CYC - 1);
   logic [15:0] to_cnt;
   logic        timeout;
   logic        to_hit;

   assign to_hit    = (state == WAIT_FIN) && (to_cnt == TO_END) && !fin_rise;
   assign frame_end = fin_rise || to_hit;
`else
   assign frame_end = fin_rise;
`endif

   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) state <= IDLE;
      else            state <= state_nx;
   end

   always_comb begin
      state_nx         = state;
      bus.o_busy       = 1'b1;
      bus.o_done       = 1'b0;
      bus.o_rd_en      = 1'b0;
      bus.o_rd_addr    = '0;
      bus.o_valid      = 1'b0;
      bus.o_wb         = 1'b0;
      bus.o_item_rst_n = 1'b1;
      case (state)
         IDLE: begin
            bus.o_busy = 1'b0;
            if (bus.i_start) state_nx = CLR;
         end
         CLR: begin
            bus.o_item_rst_n = 1'b0;
            if (clr_cnt == CLR_END) state_nx = FETCH;
         end
         FETCH: begin
            bus.o_rd_en   = 1'b1;
            bus.o_rd_addr = pix_idx;
            state_nx      = ISSUE;
         end
         ISSUE: begin
            bus.o_valid = 1'b1;
            bus.o_wb    = bus.i_rd_data;
            state_nx    = GAP;
         end
         GAP: begin
            if (slot_cnt == SLOT_END)
               state_nx = (pix_idx == LAST_PIX) ? WAIT_FIN : FETCH;
         end
         WAIT_FIN: begin
            if (frame_end) state_nx = DONE;
         end
         DONE: begin
            bus.o_busy = 1'b0;
            bus.o_done = 1'b1;
            state_nx   = IDLE;
         end
         default: begin
            bus.o_busy = 1'b0;
            state_nx   = IDLE;
         end
      endcase
   end

   // Edge detector is primed high on start so a finish level left over
   // from the previous frame cannot complete the new one.
   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         clr_cnt  <= '0;
         slot_cnt <= '0;
         pix_idx  <= '0;
         fin_d    <= 1'b1;
         smax     <= '0;
      end else begin
         fin_d <= bus.i_finish;
         case (state)
            IDLE: begin
               if (bus.i_start) begin
                  smax    <= bus.i_smax;
                  fin_d   <= 1'b1;
                  clr_cnt <= '0;
               end
            end
            CLR: begin
               clr_cnt <= clr_cnt + 3'd1;
               pix_idx <= '0;
            end
            FETCH: slot_cnt <= 4'd1;
            ISSUE: slot_cnt <= slot_cnt + 4'd1;
            GAP: begin
               slot_cnt <= slot_cnt + 4'd1;
               if (slot_cnt == SLOT_END && pix_idx != LAST_PIX)
                  pix_idx <= pix_idx + 1'b1;
            end
            default: ;
         endcase
      end
   end

   assign bus.o_smax = smax;

`ifdef DIV_RECT_SEQ_TIMEOUT_EN
   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         to_cnt  <= '0;
         timeout <= 1'b0;
      end else begin
         to_cnt <= (state == WAIT_FIN) ? to_cnt + 16'd1 : 16'd0;
         if (state == IDLE && bus.i_start) timeout <= 1'b0;
         else if (to_hit)                  timeout <= 1'b1;
      end
   end

   assign bus.o_timeout = timeout;
`endif

endmodule
`default_nettype wire

// File: tb/tb_div_rect_seq.sv
`default_nettype none
// =====================================================================
// tb_div_rect_seq : directed self-checking bench for div_rect_seq
// Rev 1.0
// =====================================================================
module tb_div_rect_seq;

   localparam int DX = 4, DY = 2, AW = 10, SLOT = 8, CLR_LEN = 2;

   logic clk;
   logic rst_n;

   div_rect_seq_if #(.AW(AW)) bus ();

   div_rect_seq #(
      .DX(DX), .DY(DY), .AW(AW), .SLOT(SLOT), .CLR_LEN(CLR_LEN)
`ifdef DIV_RECT_SEQ_TIMEOUT_EN
      , .TO_CYC(16)
`endif
   ) dut (
      .sys_clk   (clk),
      .sys_rst_n (rst_n),
      .bus       (bus.slave)
   );

   always #5 clk = ~clk;

   bit map [0:7];

   // map RAM: one-cycle read latency
   always @(posedge clk)
      if (bus.o_rd_en) bus.i_rd_data <= map[bus.o_rd_addr[2:0]];

   int total = 0;
   int bad   = 0;
   int cyc;
   int clr_n;
   int done_n;
   int rd_cyc[$];
   int rd_addr[$];
   int v_cyc[$];
   int v_wb[$];
   int lv;
   bit inj;

   task automatic check(input string tag, input int got, input int exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%0d exp=%0d", tag, got, exp);
      end
   endtask

   task automatic step();
      @(negedge clk);
      cyc++;
      if (bus.o_rd_en) begin
         rd_cyc.push_back(cyc);
         rd_addr.push_back(int'(bus.o_rd_addr));
      end
      if (bus.o_valid) begin
         v_cyc.push_back(cyc);
         v_wb.push_back(int'(bus.o_wb));
      end
      if (!bus.o_item_rst_n) clr_n++;
      if (bus.o_done) done_n++;
   endtask

   task automatic clear_log();
      cyc = 0; clr_n = 0; done_n = 0;
      rd_cyc.delete(); rd_addr.delete(); v_cyc.delete(); v_wb.delete();
   endtask

   task automatic set_map(input bit [7:0] p);
      for (int i = 0; i < 8; i++) map[i] = p[7-i];
   endtask

   task automatic do_start(input logic [7:0] s);
      bus.i_start = 1'b1;
      bus.i_smax  = s;
      step();
      bus.i_start = 1'b0;
   endtask

   task automatic check_frame(input string tag, input bit [7:0] p, input int s);
      check({tag, "_clr_len"}, clr_n, CLR_LEN);
      check({tag, "_smax"}, int'(bus.o_smax), s);
      check({tag, "_n_rd"}, rd_cyc.size(), 8);
      check({tag, "_n_valid"}, v_cyc.size(), 8);
      if (rd_cyc.size() > 0) check({tag, "_first_rd_cyc"}, rd_cyc[0], CLR_LEN + 1);
      for (int i = 0; i < 8 && i < rd_cyc.size() && i < v_cyc.size(); i++) begin
         check($sformatf("%s_addr%0d", tag, i), rd_addr[i], i);
         check($sformatf("%s_lat%0d", tag, i), v_cyc[i] - rd_cyc[i], 1);
         check($sformatf("%s_wb%0d", tag, i), v_wb[i], int'(p[7-i]));
         if (i > 0) check($sformatf("%s_gap%0d", tag, i), rd_cyc[i] - rd_cyc[i-1], SLOT);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got=timeout exp=finish");
      $fatal(1);
   end

   initial begin
      clk = 1'b0; rst_n = 1'b0;
      bus.i_start = 1'b0; bus.i_smax = '0; bus.i_finish = 1'b0;
      set_map(8'b10110010);
      repeat (3) @(negedge clk);

      check("rst_busy", bus.o_busy, 0);
      check("rst_done", bus.o_done, 0);
      check("rst_rd_en", bus.o_rd_en, 0);
      check("rst_addr", int'(bus.o_rd_addr), 0);
      check("rst_valid", bus.o_valid, 0);
      check("rst_smax", int'(bus.o_smax), 0);
      check("rst_item_rst_n", bus.o_item_rst_n, 1);
`ifdef DIV_RECT_SEQ_TIMEOUT_EN
      check("rst_timeout", bus.o_timeout, 0);
`endif
      rst_n = 1'b1;
      @(negedge clk);

      // Frame A: basic frame, ignored start in GAP of pixel 3, finish edge
      clear_log();
      do_start(8'd3);
      check("a_busy", bus.o_busy, 1);
      inj = 0;
      while (v_cyc.size() < 8 && cyc < 200) begin
         step();
         if (v_cyc.size() == 4 && !inj) begin
            step();
            bus.i_start = 1'b1; bus.i_smax = 8'd9;
            step();
            bus.i_start = 1'b0;
            inj = 1;
         end
      end
      check_frame("a", 8'b10110010, 3);
      lv = (v_cyc.size() > 0) ? v_cyc[$] : cyc;
      while (cyc < lv + 20) step();
      check("a_no_early_done", done_n, 0);
      check("a_busy_wait", bus.o_busy, 1);
      bus.i_finish = 1'b1;
      step();
      check("a_done", bus.o_done, 1);
      check("a_busy_fall", bus.o_busy, 0);
`ifdef DIV_RECT_SEQ_TIMEOUT_EN
      check("a_no_timeout", bus.o_timeout, 0);
`endif
      step();
      check("a_done_pulse", bus.o_done, 0);

      // Frame B: finish still high from frame A
      set_map(8'b01101001);
      clear_log();
      do_start(8'd5);
      while (v_cyc.size() < 8 && cyc < 200) step();
      check_frame("b", 8'b01101001, 5);
      lv = (v_cyc.size() > 0) ? v_cyc[$] : cyc;
`ifdef DIV_RECT_SEQ_TIMEOUT_EN
      // WAIT_FIN entered 7 cycles after the last strobe, then 16 cycles
      while (cyc < lv + 22) step();
      check("b_no_early_to", done_n, 0);
      step();
      check("b_to_done", bus.o_done, 1);
      check("b_to_flag", bus.o_timeout, 1);
      step();
      check("b_to_done_pulse", bus.o_done, 0);
      check("b_to_hold", bus.o_timeout, 1);
      bus.i_finish = 1'b0;
`else
      while (cyc < lv + 40) step();
      check("b_held_no_done", done_n, 0);
      check("b_busy_hold", bus.o_busy, 1);
      bus.i_finish = 1'b0;
      step(); step();
      check("b_fall_no_done", done_n, 0);
      bus.i_finish = 1'b1;
      step();
      check("b_done", bus.o_done, 1);
      bus.i_finish = 1'b0;
      step();
`endif

      // Frame C: reset while pixel 5 is being fetched
      set_map(8'b00000100);
      clear_log();
      do_start(8'd7);
`ifdef DIV_RECT_SEQ_TIMEOUT_EN
      check("c_to_clear", bus.o_timeout, 0);
`endif
      while (rd_cyc.size() < 6 && cyc < 200) step();
      check("c_reach_p5", int'(bus.o_rd_addr), 5);
      rst_n = 1'b0;
      #1;
      check("c_rst_busy", bus.o_busy, 0);
      check("c_rst_rd_en", bus.o_rd_en, 0);
      check("c_rst_addr", int'(bus.o_rd_addr), 0);
      check("c_rst_smax", int'(bus.o_smax), 0);
      check("c_rst_valid", bus.o_valid, 0);
      check("c_rst_item_rst_n", bus.o_item_rst_n, 1);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      // Frame D: full restart; finish pulse mid-frame must be ignored
      set_map(8'b11001010);
      clear_log();
      do_start(8'd2);
      inj = 0;
      while (v_cyc.size() < 8 && cyc < 200) begin
         step();
         if (v_cyc.size() == 2 && !inj) begin
            bus.i_finish = 1'b1;
            step(); step();
            bus.i_finish = 1'b0;
            inj = 1;
         end
      end
      check_frame("d", 8'b11001010, 2);
      check("d_no_spurious_done", done_n, 0);
      lv = (v_cyc.size() > 0) ? v_cyc[$] : cyc;
      while (cyc < lv + 10) step();
      bus.i_finish = 1'b1;
      step();
      check("d_done", bus.o_done, 1);
      step();
      check("d_idle", bus.o_busy, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/div_rect_seq.md
Name: div_rect_seq

Overview:
- Sequencer for the rectangle-division datapath; sits between the binarized corrosion-map RAM and the connected-region rectangle extractor.
- On a start pulse it clears the extractor's result register, then streams every map pixel in raster order, one pixel per fixed slot, because the extractor needs several cycles per pixel.
- It then waits for the extractor's finish flag and reports completion to the frame controller.

Parameters:
- DX, 32: map width in pixels (columns per row).
- DY, 24: map height in pixels (rows).
- AW, 10: map RAM address width; DX*DY <= 2**AW.
- SLOT, 8: cycles per pixel slot; legal range 6..15.
- CLR_LEN, 2: cycles o_item_rst_n is held low at frame start; legal range 1..7.

Ports:
- sys_clk  in  1  clock
- sys_rst_n  in  1  async active-low reset
- i_start  in  1  one-cycle start pulse from the frame controller
- i_smax  in  8  minimum rectangle side; latched at start
- o_busy  out  1  high from accepted start until o_done
- o_done  out  1  one-cycle pulse when the extractor reports finish
- o_rd_en  out  1  map RAM read enable
- o_rd_addr  out  AW  map RAM address (row*DX + col)
- i_rd_data  in  1  map pixel, valid exactly one cycle after o_rd_en
- o_valid  out  1  pixel strobe to the extractor
- o_wb  out  1  pixel value to the extractor (1 = white)
- o_smax  out  8  latched threshold to the extractor
- o_item_rst_n  out  1  extractor result-register clear, active-low
- i_finish  in  1  extractor finish flag (level; only its rising edge is used)

Behaviour:
- Reset values: o_busy=0, o_done=0, o_rd_en=0, o_rd_addr=0, o_valid=0, o_wb=0, o_smax=0, o_item_rst_n=1. State=IDLE, all counters 0.
- The design uses binary-encoded states IDLE, CLR, FETCH, ISSUE, GAP, WAIT_FIN, DONE.
- IDLE:
  - i_start=1 latches i_smax into o_smax, sets o_busy=1 and moves to CLR.
  - i_start is ignored in every other state; it is not queued.
- CLR:
  - o_item_rst_n=0 for exactly CLR_LEN cycles.
  - Then o_item_rst_n=1, the pixel index is set to 0, and the block goes to FETCH.
- FETCH (1 cycle):
  - o_rd_en=1, o_rd_addr=pixel index.
  - The slot counter loads 1.
  - The next state is ISSUE.
- ISSUE (1 cycle):
  - o_valid=1, o_wb=i_rd_data, so the strobe appears 1 cycle after o_rd_en.
  - The slot counter increments.
  - The next state is GAP.
- GAP:
  - The slot counter increments each cycle.
  - When it reaches SLOT-1:
    - Last pixel (index DX*DY-1): go to WAIT_FIN.
    - Otherwise: increment the index and go to FETCH.
  - FETCH-to-FETCH spacing is therefore exactly SLOT cycles, and o_valid pulses are exactly SLOT cycles apart.
- Index arithmetic:
  - The pixel index is a single AW-bit counter; the column/row split is implied by the address.
  - The index never wraps during a frame; the last address is DX*DY-1.
- WAIT_FIN:
  - Rising-edge detection on i_finish uses a one-register delay.
  - The delay register is reset to 1 at start, so a flag still high from the previous frame is not taken as an edge.
  - A rising edge moves the block to DONE.
- DONE (1 cycle): o_done=1, o_busy=0, then IDLE.
- Outputs not listed for a state are 0 (o_item_rst_n is 1); o_smax holds until the next accepted start.
- Reset mid-frame:
  - All outputs return to their reset values immediately (asynchronous).
  - A partially fed frame is abandoned; the next start performs the full CLR again.
- An i_finish edge outside WAIT_FIN is ignored.

Optional Feature:
- Macro: DIV_RECT_SEQ_TIMEOUT_EN.
- With the macro defined:
  - Extra parameter TO_CYC, default 1024.
  - Extra output o_timeout (1 bit, reset 0).
  - A 16-bit counter runs in WAIT_FIN. If it reaches TO_CYC with no i_finish edge, the block goes to DONE anyway, and o_timeout=1 in the same cycle as o_done.
  - o_timeout clears on the next accepted start.
- Without the macro: no o_timeout port and no counter; WAIT_FIN waits indefinitely.

Test Plan:
- Basic frame:
  - Setup: DX=4, DY=2, SLOT=8, CLR_LEN=2; start with i_smax=3.
  - Required: o_item_rst_n low for exactly 2 cycles; o_smax=3.
  - Required: 8 o_rd_en pulses at addresses 0..7, 8 cycles apart; each o_valid exactly 1 cycle after its o_rd_en.
- Pixel data: map pattern 1,0,1,1,0,0,1,0 -> o_wb on the successive o_valid pulses equals exactly that sequence.
- Finish handling:
  - i_finish rises 20 cycles after the last o_valid -> o_done pulses exactly 1 cycle later; o_busy falls in the o_done cycle.
  - i_finish already high at start and held high -> no o_done until it drops and rises again.
- Ignored start: i_start pulsed during GAP of pixel 3 -> no restart; addresses continue 4..7; o_smax unchanged.
- Reset mid-frame: sys_rst_n asserted during pixel 5 -> all outputs at reset values at once; a new start restarts from CLR and address 0.
- Timeout (macro defined, TO_CYC=16): i_finish never rises -> o_done and o_timeout both high 16 cycles after entering WAIT_FIN.
